// File: rtl/controlador_jogada.sv
// controlador_jogada
//   Holds the 81-cell Sudoku board, moves the player's cursor and commits
//   moves after a 9-cycle row/column/box conflict scan.
//
//   clk, reset_n             clock (rising edge) / asynchronous active-low reset
//   switchCod                digit code: 0 = clear, 1-9 = digit, 10-15 = invalid
//   btn_confirma, btn_cima,
//   btn_baixo, btn_esq,
//   btn_dir                  raw active-high buttons (synchronised here)
//   carregar_en/addr/dado/fixo  puzzle load port, one cell per cycle, IDLE only
//   leitura_addr             display read index
//   leitura_dado/fixo        registered cell value / fixed bit (1-cycle latency)
//   cursor_lin, cursor_col   cursor position 0-8
//   ocupado                  high while a move is being processed
//   aceito, rejeitado        1-cycle pulses on move commit / refusal
//   preenchidas, completo    non-zero cell count, board-full flag
module controlador_jogada #(
    parameter int SYNC_STAGES = 2,
    parameter bit CURSOR_WRAP = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] switchCod,
    input  logic       btn_confirma,
    input  logic       btn_cima,
    input  logic       btn_baixo,
    input  logic       btn_esq,
    input  logic       btn_dir,
    input  logic       carregar_en,
    input  logic [6:0] carregar_addr,
    input  logic [3:0] carregar_dado,
    input  logic       carregar_fixo,
    input  logic [6:0] leitura_addr,
    output logic [3:0] leitura_dado,
    output logic       leitura_fixo,
    output logic [3:0] cursor_lin,
    output logic [3:0] cursor_col,
    output logic       ocupado,
    output logic       aceito,
    output logic       rejeitado,
    output logic [6:0] preenchidas,
    output logic       completo
);

    typedef enum logic [1:0] {IDLE, CHECK, WRITE, REJECT} estado_t;

    localparam int unsigned B_DIR   = 0;
    localparam int unsigned B_ESQ   = 1;
    localparam int unsigned B_CIMA  = 2;
    localparam int unsigned B_BAIXO = 3;
    localparam int unsigned B_CONF  = 4;
    localparam int unsigned NS      = SYNC_STAGES;
    localparam logic [7:0]  WARM_MAX = 8'(SYNC_STAGES + 1);

    function automatic logic [6:0] idx(input logic [3:0] r, input logic [3:0] c);
        return 7'(r) * 7'd9 + 7'(c);
    endfunction

    function automatic logic [3:0] div3(input logic [3:0] v);
        return (v >= 4'd6) ? 4'd2 : (v >= 4'd3) ? 4'd1 : 4'd0;
    endfunction

    function automatic logic [3:0] passo(input logic [3:0] v, input logic inc, input logic dec);
        logic [3:0] r;
        r = v;
        if (inc && !dec)
            r = (v == 4'd8) ? (CURSOR_WRAP ? 4'd0 : 4'd8) : v + 4'd1;
        else if (dec && !inc)
            r = (v == 4'd0) ? (CURSOR_WRAP ? 4'd8 : 4'd0) : v - 4'd1;
        return r;
    endfunction

    // ---------------- button synchronisers / edge detect ----------------
    logic [4:0] btn_raw;
    logic [4:0] sync_q [NS];
    logic [4:0] prev_q;
    logic [7:0] warm_q;
    logic       armed;
    logic [4:0] pulso;

    assign btn_raw = {btn_confirma, btn_baixo, btn_cima, btn_esq, btn_dir};
    // Edge detection stays masked until the synchroniser has flushed once,
    // so a button held across reset release is absorbed without a pulse.
    assign armed   = (warm_q == WARM_MAX);
    assign pulso   = sync_q[NS-1] & ~prev_q & {5{armed}};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '{default: '0};
            prev_q <= '0;
            warm_q <= '0;
        end else begin
            sync_q[0] <= btn_raw;
            for (int unsigned i = 1; i < NS; i++)
                sync_q[i] <= sync_q[i-1];
            prev_q <= sync_q[NS-1];
            if (!armed)
                warm_q <= warm_q + 8'd1;
        end
    end

    // ---------------- board storage ----------------
    logic [3:0] tab [81];
    logic       fixo [81];

    estado_t    estado;
    logic [3:0] d_q, l_q, c_q, k_q;
    logic       conflito;

    logic       load_ok, wr_en;
    logic [6:0] wr_addr;
    logic [3:0] wr_dado, wr_old;
    logic [6:0] cnt_next;

    always_comb begin
        load_ok = (estado == IDLE) && carregar_en && (carregar_addr < 7'd81);
        wr_en   = 1'b0;
        wr_addr = idx(l_q, c_q);
        wr_dado = d_q;
        if (estado == WRITE) begin
            wr_en = 1'b1;
        end else if (load_ok) begin
            wr_en   = 1'b1;
            wr_addr = carregar_addr;
            wr_dado = carregar_dado;
        end
        wr_old   = tab[wr_addr];
        cnt_next = preenchidas;
        if (wr_en) begin
            if (wr_old == 4'd0 && wr_dado != 4'd0)
                cnt_next = preenchidas + 7'd1;
            else if (wr_old != 4'd0 && wr_dado == 4'd0)
                cnt_next = preenchidas - 7'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tab  <= '{default: '0};
            fixo <= '{default: 1'b0};
        end else if (wr_en) begin
            tab[wr_addr] <= wr_dado;
            if (load_ok)
                fixo[wr_addr] <= carregar_fixo;
        end
    end

    // ---------------- read port ----------------
    logic [6:0] rd_idx;
    logic       rd_ok;
    assign rd_ok  = (leitura_addr < 7'd81);
    assign rd_idx = rd_ok ? leitura_addr : 7'd0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            leitura_dado <= '0;
            leitura_fixo <= 1'b0;
        end else begin
            leitura_dado <= rd_ok ? tab[rd_idx] : 4'd0;
            leitura_fixo <= rd_ok ? fixo[rd_idx] : 1'b0;
        end
    end

    // ---------------- conflict scan (one k per cycle) ----------------
    logic [3:0] box_r, box_c;
    logic       hit;

    always_comb begin
        box_r = 4'd3 * div3(l_q) + div3(k_q);
        box_c = 4'd3 * div3(c_q) + (k_q - 4'd3 * div3(k_q));
        hit   = 1'b0;
        if (k_q != c_q && tab[idx(l_q, k_q)] == d_q)
            hit = 1'b1;
        if (k_q != l_q && tab[idx(k_q, c_q)] == d_q)
            hit = 1'b1;
        if (!(box_r == l_q && box_c == c_q) && tab[idx(box_r, box_c)] == d_q)
            hit = 1'b1;
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            estado      <= IDLE;
            cursor_lin  <= '0;
            cursor_col  <= '0;
            d_q         <= '0;
            l_q         <= '0;
            c_q         <= '0;
            k_q         <= '0;
            conflito    <= 1'b0;
            ocupado     <= 1'b0;
            aceito      <= 1'b0;
            rejeitado   <= 1'b0;
            preenchidas <= '0;
            completo    <= 1'b0;
        end else begin
            aceito      <= 1'b0;
            rejeitado   <= 1'b0;
            preenchidas <= cnt_next;
            completo    <= (cnt_next == 7'd81);
            case (estado)
                IDLE: begin
                    // A load in the same cycle swallows the confirm pulse.
                    if (pulso[B_CONF] && !carregar_en) begin
                        d_q      <= switchCod;
                        l_q      <= cursor_lin;
                        c_q      <= cursor_col;
                        k_q      <= '0;
                        conflito <= 1'b0;
                        ocupado  <= 1'b1;
                        if (fixo[idx(cursor_lin, cursor_col)] || switchCod >= 4'd10)
                            estado <= REJECT;
                        else if (switchCod == 4'd0)
                            estado <= WRITE;
                        else
                            estado <= CHECK;
                    end
                    if (!pulso[B_CONF]) begin
                        cursor_lin <= passo(cursor_lin, pulso[B_BAIXO], pulso[B_CIMA]);
                        cursor_col <= passo(cursor_col, pulso[B_DIR], pulso[B_ESQ]);
                    end
                end
                CHECK: begin
                    conflito <= conflito | hit;
                    k_q      <= k_q + 4'd1;
                    if (k_q == 4'd8)
                        estado <= (conflito | hit) ? REJECT : WRITE;
                end
                WRITE: begin
                    aceito  <= 1'b1;
                    ocupado <= 1'b0;
                    estado  <= IDLE;
                end
                REJECT: begin
                    rejeitado <= 1'b1;
                    ocupado   <= 1'b0;
                    estado    <= IDLE;
                end
                default: begin
                    ocupado <= 1'b0;
                    estado  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/controlador_jogada.md
Name: controlador_jogada

Overview:
- Consumes the priority-encoded digit code (0 = no switch, 1-9 = digit) produced by the switch encoder stage.
- Combines it with the player's cursor and confirm buttons and commits a move into the 81-cell Sudoku board held here.
- Each move is checked for row, column and 3x3-box conflicts by a sequential 9-cycle scan.
- Provides the board read port and game-status flags to the display and score stages.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on each raw button input before edge detection (min 2).
- CURSOR_WRAP, 1, 1 = cursor wraps 8↔0; 0 = cursor saturates at 0 and 8.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- switchCod  input  4  digit code from encoder; 0 = clear, 1-9 = digit, 10-15 = invalid.
- btn_confirma  input  1  raw confirm button, active-high.
- btn_cima, btn_baixo, btn_esq, btn_dir  input  1 each  raw cursor buttons, active-high.
- carregar_en  input  1  puzzle-load strobe, one cell per cycle.
- carregar_addr  input  7  load cell index 0-80 (lin*9+col); values ≥81 are ignored.
- carregar_dado  input  4  load value 0-9.
- carregar_fixo  input  1  marks the loaded cell as fixed (given).
- leitura_addr  input  7  display read index.
- leitura_dado  output  4  board[leitura_addr], registered, 1-cycle latency; 0 if addr ≥81.
- leitura_fixo  output  1  fixed bit of the same cell, same timing.
- cursor_lin, cursor_col  output  4 each  cursor position 0-8.
- ocupado  output  1  high while state ≠ IDLE.
- aceito  output  1  1-cycle pulse when a move commits.
- rejeitado  output  1  1-cycle pulse when a move is refused.
- preenchidas  output  7  count of non-zero cells, 0-81.
- completo  output  1  high when preenchidas == 81.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - Board and fixed bits cleared; cursor (0,0); state IDLE; preenchidas 0.
  - All outputs 0, including leitura_*.
  - Synchronizer and edge-detect flops are cleared, so a button held through reset release produces no pulse.
- Buttons:
  - Each raw button passes through SYNC_STAGES flops, then a rising-edge detector gives a 1-cycle internal pulse.
  - Holding a button produces exactly one pulse.
- Cursor:
  - Pulses act only in IDLE and are dropped otherwise.
  - Up/down adjust cursor_lin; left/right adjust cursor_col, with wrap or saturation per CURSOR_WRAP.
  - Up+down in the same cycle cancel; likewise left+right. A vertical and a horizontal move in the same cycle both apply.
  - If confirm pulses in the same cycle as a move, confirm wins and the move is dropped.
- FSM states: IDLE, CHECK, WRITE, REJECT.
- IDLE + confirm:
  - Latch D = switchCod, L = cursor_lin, C = cursor_col.
  - Cell (L,C) fixed, or D ≥ 10 → REJECT.
  - D == 0 → WRITE (clear; no check).
  - Otherwise → CHECK with k = 0.
- CHECK (exactly 9 cycles, k = 0..8). In cycle k, compare D against:
  - board[L][k] when k ≠ C;
  - board[k][C] when k ≠ L;
  - box cell (3*(L/3)+k/3, 3*(C/3)+k%3) when it is not (L,C).
  - Any match sets a sticky conflict flag. After k=8: conflict → REJECT, else → WRITE.
  - The flag clears on entry to CHECK.
- WRITE (1 cycle):
  - board[L][C] ← D; aceito=1; → IDLE.
  - preenchidas +1 if old value is 0 and D ≠ 0; −1 if old ≠ 0 and D = 0; unchanged otherwise.
- REJECT (1 cycle): rejeitado=1; board unchanged; → IDLE.
- Latency: confirm pulse to aceito/rejeitado is 11 cycles via CHECK and 2 cycles via the direct paths, counted from the IDLE cycle that sees the pulse.
- Load:
  - Accepted only in IDLE with carregar_addr < 81. Writes value and fixed bit and updates preenchidas by the same rule as WRITE.
  - If carregar_en and a confirm pulse occur in the same cycle, load wins and the confirm is dropped.
  - carregar_en outside IDLE is ignored.
- switchCod changes after the latch have no effect on the move in progress.
- reset_n asserted mid-CHECK aborts the move: no aceito/rejeitado, and the board returns to its reset state.

Test Plan:
- Reset, then hold btn_dir through reset release → cursor (0,0), ocupado 0, preenchidas 0, completo 0, no cursor motion; a fresh btn_dir press → cursor_col 1.
- CURSOR_WRAP=1: btn_esq at col 0 → col 8; btn_cima at lin 0 → lin 8. CURSOR_WRAP=0: same presses leave 0.
- Load 5 at addr 3 (row 0, col 3). Cursor (0,0), switchCod=5, confirm → ocupado for 10 cycles, then rejeitado pulse; leitura at addr 0 = 0; preenchidas stays 1.
- Empty board, cursor (4,4), switchCod=7, confirm → aceito exactly 11 cycles after the IDLE pulse cycle; leitura_addr=40 gives 7 one cycle later; preenchidas 1. Then switchCod=0, confirm → aceito after 2 cycles, cell 0, preenchidas 0.
- Load addr 10 = 3 with fixo=1; cursor (1,1), any digit, confirm → rejeitado after 2 cycles; cell still 3. switchCod=12 on a free cell → rejeitado.
- Load a valid 80-cell puzzle, confirm the missing digit → completo 1. Separately, pulse reset_n low during CHECK → no aceito/rejeitado, board cleared, state IDLE.
